// File: rtl/cvp14_bus_tracer.sv
// cvp14_bus_tracer: passive tracer for the CVP14 processor-to-staticram bus.
// Each read or write transaction is recorded into a first-word-fall-through
// trace FIFO. The block also keeps saturating read and write counters and
// sticky flags for overflow and RD/WR conflicts.
//
// Ports:
//   Clk1, Reset_n         clock; asynchronous active-low reset
//   Enable, Clear         transaction detect enable; synchronous clear
//   Addr, RD, WR, Wdata   processor side of the bus
//   Rdata                 RAM read data (sampled 1 cycle after the RD rise)
//   Pop                   consume the FIFO head entry
//   Trace_valid/wr/addr/data  head entry (combinational, 0 when empty)
//   Count                 FIFO occupancy
//   Rd_count, Wr_count    saturating transaction counters
//   Overflow, Conflict    sticky status flags
//
// Optional feature (macro BUSMON_WATCH_EN): adds the Watch_addr input and the
// sticky Watch_hit output. After a hit, new transaction detection is frozen.
module cvp14_bus_tracer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 16
) (
    input  logic                     Clk1,
    input  logic                     Reset_n,
    input  logic                     Enable,
    input  logic                     Clear,
    input  logic [AW-1:0]            Addr,
    input  logic                     RD,
    input  logic                     WR,
    input  logic [DW-1:0]            Wdata,
    input  logic [DW-1:0]            Rdata,
    input  logic                     Pop,
`ifdef BUSMON_WATCH_EN
    input  logic [AW-1:0]            Watch_addr,
    output logic                     Watch_hit,
`endif
    output logic                     Trace_valid,
    output logic                     Trace_wr,
    output logic [AW-1:0]            Trace_addr,
    output logic [DW-1:0]            Trace_data,
    output logic [$clog2(DEPTH):0]   Count,
    output logic [15:0]              Rd_count,
    output logic [15:0]              Wr_count,
    output logic                     Overflow,
    output logic                     Conflict
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t        state;
    logic          rd_q, wr_q;
    logic [AW-1:0] addr_pend;
    entry_t        skid;
    logic          skid_v;
    entry_t        mem [DEPTH];
    logic [PW-1:0] wptr, rptr;

    logic   en_c, rd_start_c, wr_start_c, skid_load_c;
    logic   push_c, push_ok_c, pop_ok_c, drop_c, empty_c, full_c;
    entry_t push_e_c, head_c;

`ifdef BUSMON_WATCH_EN
    // A watch hit freezes detection from the cycle after it registers.
    assign en_c = Enable & ~Watch_hit;
`else
    assign en_c = Enable;
`endif

    assign rd_start_c  = RD & ~rd_q & ~WR & en_c;
    assign wr_start_c  = WR & ~wr_q & ~RD & en_c;
    assign skid_load_c = wr_start_c & (state == RD_WAIT);

    // Push source: read completion first, then the skid, then a fresh write.
    always_comb begin
        push_c   = 1'b0;
        push_e_c = '0;
        if (state == RD_WAIT) begin
            push_c   = 1'b1;
            push_e_c = entry_t'({1'b0, addr_pend, Rdata});
        end else if (skid_v) begin
            push_c   = 1'b1;
            push_e_c = skid;
        end else if (wr_start_c) begin
            push_c   = 1'b1;
            push_e_c = entry_t'({1'b1, Addr, Wdata});
        end
    end

    assign empty_c   = (Count == '0);
    assign full_c    = (Count == CW'(DEPTH));
    assign pop_ok_c  = Pop & ~empty_c;
    assign push_ok_c = push_c & (~full_c | pop_ok_c);
    assign drop_c    = push_c & ~push_ok_c;

    // Strobe history; keeps updating through Clear and Enable=0.
    always_ff @(posedge Clk1 or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
        end else begin
            rd_q <= RD;
            wr_q <= WR;
        end
    end

    // Read FSM and write skid register.
    always_ff @(posedge Clk1 or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            addr_pend <= '0;
            skid      <= '0;
            skid_v    <= 1'b0;
        end else if (Clear) begin
            state  <= IDLE;
            skid_v <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_start_c) begin
                        addr_pend <= Addr;
                        state     <= RD_WAIT;
                    end
                end
                RD_WAIT: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (skid_load_c) begin
                skid   <= entry_t'({1'b1, Addr, Wdata});
                skid_v <= 1'b1;
            end else begin
                skid_v <= 1'b0;
            end
        end
    end

    // Trace FIFO storage, pointers, occupancy and overflow flag.
    always_ff @(posedge Clk1 or negedge Reset_n) begin
        if (!Reset_n) begin
            mem      <= '{default: '0};
            wptr     <= '0;
            rptr     <= '0;
            Count    <= '0;
            Overflow <= 1'b0;
        end else if (Clear) begin
            wptr     <= '0;
            rptr     <= '0;
            Count    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (push_ok_c) begin
                mem[wptr] <= push_e_c;
                wptr      <= wptr + PW'(1);
            end
            if (pop_ok_c) begin
                rptr <= rptr + PW'(1);
            end
            if (push_ok_c && !pop_ok_c) begin
                Count <= Count + CW'(1);
            end else if (!push_ok_c && pop_ok_c) begin
                Count <= Count - CW'(1);
            end
            if (drop_c) begin
                Overflow <= 1'b1;
            end
        end
    end

    // Saturating transaction counters (dropped entries still count).
    always_ff @(posedge Clk1 or negedge Reset_n) begin
        if (!Reset_n) begin
            Rd_count <= '0;
            Wr_count <= '0;
            Conflict <= 1'b0;
        end else if (Clear) begin
            Rd_count <= '0;
            Wr_count <= '0;
            Conflict <= 1'b0;
        end else begin
            if (rd_start_c && (Rd_count != 16'hFFFF)) begin
                Rd_count <= Rd_count + 16'd1;
            end
            if (wr_start_c && (Wr_count != 16'hFFFF)) begin
                Wr_count <= Wr_count + 16'd1;
            end
            if (RD && WR) begin
                Conflict <= 1'b1;
            end
        end
    end

`ifdef BUSMON_WATCH_EN
    // Sticky watch hit on any accepted push whose address matches.
    always_ff @(posedge Clk1 or negedge Reset_n) begin
        if (!Reset_n) begin
            Watch_hit <= 1'b0;
        end else if (Clear) begin
            Watch_hit <= 1'b0;
        end else if (push_ok_c && (push_e_c.addr == Watch_addr)) begin
            Watch_hit <= 1'b1;
        end
    end
`endif

    // Head entry, forced to zero while empty.
    assign head_c      = mem[rptr];
    assign Trace_valid = ~empty_c;
    assign Trace_wr    = empty_c ? 1'b0 : head_c.wr;
    assign Trace_addr  = empty_c ? '0 : head_c.addr;
    assign Trace_data  = empty_c ? '0 : head_c.data;

endmodule

// File: tb/tb_cvp14_bus_tracer.sv
// Testbench for cvp14_bus_tracer: directed scenarios plus randomized bus
// traffic, checked against a transaction-level reference model.
module tb_cvp14_bus_tracer;

    localparam int unsigned DEPTH = 16;

    logic        Clk1;
    logic        Reset_n, Enable, Clear, RD, WR, Pop;
    logic [15:0] Addr, Wdata, Rdata;
    logic        Trace_valid, Trace_wr, Overflow, Conflict;
    logic [15:0] Trace_addr, Trace_data, Rd_count, Wr_count;
    logic [4:0]  Count;

    cvp14_bus_tracer #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
        .Clk1(Clk1), .Reset_n(Reset_n), .Enable(Enable), .Clear(Clear),
        .Addr(Addr), .RD(RD), .WR(WR), .Wdata(Wdata), .Rdata(Rdata), .Pop(Pop),
        .Trace_valid(Trace_valid), .Trace_wr(Trace_wr), .Trace_addr(Trace_addr),
        .Trace_data(Trace_data), .Count(Count), .Rd_count(Rd_count),
        .Wr_count(Wr_count), .Overflow(Overflow), .Conflict(Conflict)
    );

    initial Clk1 = 1'b0;
    always #5 Clk1 = ~Clk1;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: trace contents as a queue of transactions.
    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } ent_t;

    ent_t        m_q[$];
    logic        m_prev_rd, m_prev_wr;
    logic        m_rd_pend, m_def_v;
    logic [15:0] m_rd_addr;
    ent_t        m_def;
    int unsigned m_rdc, m_wrc;
    logic        m_ovf, m_cfl;

    task automatic model_reset();
        m_q.delete();
        m_prev_rd = 1'b0; m_prev_wr = 1'b0;
        m_rd_pend = 1'b0; m_def_v = 1'b0;
        m_rd_addr = '0;   m_def = '0;
        m_rdc = 0; m_wrc = 0;
        m_ovf = 1'b0; m_cfl = 1'b0;
    endtask

    // One clock edge of the model, using the inputs held across that edge.
    task automatic model_step();
        logic rs, ws, has_push, popped, was_full;
        ent_t e;
        rs = RD && !m_prev_rd && !WR && Enable;
        ws = WR && !m_prev_wr && !RD && Enable;
        if (Clear) begin
            m_q.delete();
            m_rd_pend = 1'b0; m_def_v = 1'b0;
            m_rdc = 0; m_wrc = 0;
            m_ovf = 1'b0; m_cfl = 1'b0;
        end else begin
            has_push = 1'b0;
            e = '0;
            if (m_rd_pend) begin
                // read data arrives one cycle after the RD rise; a write
                // arriving now is deferred by one cycle
                e = '{wr: 1'b0, addr: m_rd_addr, data: Rdata};
                has_push = 1'b1;
                m_rd_pend = 1'b0;
                if (ws) begin
                    m_def = '{wr: 1'b1, addr: Addr, data: Wdata};
                    m_def_v = 1'b1;
                end
            end else if (m_def_v) begin
                e = m_def;
                has_push = 1'b1;
                m_def_v = 1'b0;
            end else if (ws) begin
                e = '{wr: 1'b1, addr: Addr, data: Wdata};
                has_push = 1'b1;
            end
            if (rs) begin
                m_rd_pend = 1'b1;
                m_rd_addr = Addr;
            end
            if (rs && m_rdc < 32'hFFFF) m_rdc++;
            if (ws && m_wrc < 32'hFFFF) m_wrc++;
            if (RD && WR) m_cfl = 1'b1;
            was_full = (m_q.size() == DEPTH);
            popped = Pop && (m_q.size() > 0);
            if (popped) void'(m_q.pop_front());
            if (has_push) begin
                if (!was_full || popped) m_q.push_back(e);
                else m_ovf = 1'b1;
            end
        end
        m_prev_rd = RD;
        m_prev_wr = WR;
    endtask

    task automatic check_all();
        ent_t h;
        h = (m_q.size() > 0) ? m_q[0] : '0;
        check("count",    32'(Count),       32'(m_q.size()));
        check("valid",    32'(Trace_valid), 32'(m_q.size() > 0));
        check("tr_wr",    32'(Trace_wr),    32'(h.wr));
        check("tr_addr",  32'(Trace_addr),  32'(h.addr));
        check("tr_data",  32'(Trace_data),  32'(h.data));
        check("rd_count", 32'(Rd_count),    m_rdc);
        check("wr_count", 32'(Wr_count),    m_wrc);
        check("overflow", 32'(Overflow),    32'(m_ovf));
        check("conflict", 32'(Conflict),    32'(m_cfl));
    endtask

    task automatic step(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] rdat,
                        input logic pop, input logic en, input logic clr);
        @(negedge Clk1);
        RD = rd; WR = wr; Addr = a; Wdata = wd; Rdata = rdat;
        Pop = pop; Enable = en; Clear = clr;
        @(posedge Clk1);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic clear_step();
        step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        Reset_n = 1'b0; Enable = 1'b1; Clear = 1'b0; RD = 1'b0; WR = 1'b0;
        Pop = 1'b0; Addr = '0; Wdata = '0; Rdata = '0;
        model_reset();
        repeat (2) @(posedge Clk1);
        #1;
        check("rst_count", 32'(Count), 32'd0);
        check("rst_valid", 32'(Trace_valid), 32'd0);
        check_all();
        @(negedge Clk1);
        Reset_n = 1'b1;

        // Reset then a single write
        step(1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0, 1'b0, 1'b1, 1'b0);
        check("t1_count", 32'(Count), 32'd1);
        check("t1_wr",    32'(Trace_wr), 32'd1);
        check("t1_addr",  32'(Trace_addr), 32'h0010);
        check("t1_data",  32'(Trace_data), 32'hBEEF);
        check("t1_wrcnt", 32'(Wr_count), 32'd1);
        idle_step();

        // Read latency: data sampled one cycle after the RD rise
        clear_step();
        step(1'b1, 1'b0, 16'h0020, 16'h0, 16'hDEAD, 1'b0, 1'b1, 1'b0);
        check("t2_early", 32'(Count), 32'd0);
        step(1'b0, 1'b0, 16'h0000, 16'h0, 16'h1234, 1'b0, 1'b1, 1'b0);
        check("t2_count", 32'(Count), 32'd1);
        check("t2_wr",    32'(Trace_wr), 32'd0);
        check("t2_addr",  32'(Trace_addr), 32'h0020);
        check("t2_data",  32'(Trace_data), 32'h1234);
        check("t2_rdcnt", 32'(Rd_count), 32'd1);

        // Write rising during the read wait goes through the skid
        clear_step();
        step(1'b1, 1'b0, 16'h0021, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h0030, 16'h5555, 16'h7777, 1'b0, 1'b1, 1'b0);
        check("t3_first", 32'(Count), 32'd1);
        check("t3_head",  32'(Trace_addr), 32'h0021);
        step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        check("t3_count", 32'(Count), 32'd2);

        // Fill, overflow, write-with-pop at full, drain, pop on empty
        clear_step();
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b1, 16'(i + 16'h100), 16'(i * 3), 16'h0, 1'b0, 1'b1, 1'b0);
            idle_step();
        end
        check("t4_count", 32'(Count), 32'd16);
        check("t4_ovf",   32'(Overflow), 32'd1);
        check("t4_wrcnt", 32'(Wr_count), 32'd17);
        step(1'b0, 1'b1, 16'h0200, 16'hAAAA, 16'h0, 1'b1, 1'b1, 1'b0);
        check("t4_popfull", 32'(Count), 32'd16);
        idle_step();
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0);
        check("t4_empty", 32'(Trace_valid), 32'd0);
        step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0);
        check("t4_popempty", 32'(Count), 32'd0);

        // Conflict then Clear
        step(1'b1, 1'b1, 16'h0040, 16'h1111, 16'h0, 1'b0, 1'b1, 1'b0);
        check("t5_cfl",   32'(Conflict), 32'd1);
        check("t5_count", 32'(Count), 32'd0);
        idle_step();
        clear_step();
        check("t5_clr_cfl", 32'(Conflict), 32'd0);
        check("t5_clr_ovf", 32'(Overflow), 32'd0);
        check("t5_clr_wr",  32'(Wr_count), 32'd0);

        // Async reset while a read is pending
        step(1'b1, 1'b0, 16'h0050, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        #2;
        Reset_n = 1'b0;
        RD = 1'b0;
        #1;
        model_reset();
        check("t6_rdcnt", 32'(Rd_count), 32'd0);
        check_all();
        @(posedge Clk1);
        @(negedge Clk1);
        Reset_n = 1'b1;
        repeat (3) idle_step();
        check("t6_noentry", 32'(Count), 32'd0);

        // Randomized traffic; pop rate varies so the FIFO both fills and drains
        for (int i = 0; i < 3000; i++) begin
            logic rd, wr, pop, en, clr;
            rd  = ($urandom_range(0, 3) == 0);
            wr  = ($urandom_range(0, 2) == 0);
            pop = ((i / 500) % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            en  = ($urandom_range(0, 15) != 0);
            clr = ($urandom_range(0, 299) == 0);
            step(rd, wr, 16'($urandom), 16'($urandom), 16'($urandom), pop, en, clr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
